// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and bus widths for the instruction/data memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        INSTR = 2'd1,
        DATA  = 2'd2
    } grant_t;

    typedef struct packed {
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
        logic [c_STRB_W-1:0] wstrb;
        logic                instr;
    } mem_req_t;

    // Data port wins when it is the only requester, or when both request and
    // the previous grant went to the fetch port (or no history yet and the
    // tie-break favours data).
    function automatic logic data_wins(
        input logic   i_valid,
        input logic   d_valid,
        input grant_t last,
        input logic   data_first
    );
        logic w_tie;
        w_tie = (last == INSTR) || ((last == NONE) && data_first);
        return d_valid && (!i_valid || w_tie);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_timeout_counter.sv
// ============================================================================
// Module   : arb_timeout_counter
// Brief    : Counts grant cycles without memory_ready; flags the final cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module arb_timeout_counter #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [c_CNT_W-1:0] r_count;

    // The count equals the number of elapsed grant cycles, so expiry lands in
    // the TIMEOUT-th grant cycle.
    assign o_expired = (r_count == c_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing one memory bus between fetch and data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_pkg::*;
#(
    parameter int TIMEOUT    = 1024,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                imem_valid,
    input  logic [c_ADDR_W-1:0] imem_addr,
    output logic [c_DATA_W-1:0] imem_rdata,
    output logic                imem_ready,
    output logic                imem_err,

    input  logic                dmem_valid,
    input  logic [c_ADDR_W-1:0] dmem_addr,
    input  logic [c_DATA_W-1:0] dmem_wdata,
    input  logic [c_STRB_W-1:0] dmem_wstrb,
    output logic [c_DATA_W-1:0] dmem_rdata,
    output logic                dmem_ready,
    output logic                dmem_err,

    output logic                memory_valid,
    output logic                memory_instr,
    output logic [c_ADDR_W-1:0] memory_addr,
    output logic [c_DATA_W-1:0] memory_wdata,
    output logic [c_STRB_W-1:0] memory_wstrb,
    input  logic [c_DATA_W-1:0] memory_rdata,
    input  logic                memory_ready
);

    arb_state_t r_state;
    grant_t     r_last;
    mem_req_t   r_req;
    logic       r_mem_valid;

    logic w_in_i;
    logic w_in_d;
    logic w_busy;
    logic w_expired;
    logic w_done;
    logic w_pick_d;

    assign w_in_i   = (r_state == GRANT_I);
    assign w_in_d   = (r_state == GRANT_D);
    assign w_busy   = w_in_i || w_in_d;
    assign w_done   = memory_ready || w_expired;
    assign w_pick_d = data_wins(imem_valid, dmem_valid, r_last, DATA_FIRST);

    generate
        if (TIMEOUT > 0) begin : g_timeout
            arb_timeout_counter #(
                .TIMEOUT (TIMEOUT)
            ) u_timeout (
                .clk       (clk),
                .rst       (rst),
                .i_clear   (!w_busy),
                .i_enable  (w_busy && !memory_ready),
                .o_expired (w_expired)
            );
        end else begin : g_no_timeout
            assign w_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= NONE;
            r_req       <= '0;
            r_mem_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_req       <= '{addr: dmem_addr, wdata: dmem_wdata,
                                         wstrb: dmem_wstrb, instr: 1'b0};
                        r_mem_valid <= 1'b1;
                        r_state     <= GRANT_D;
                    end else if (imem_valid) begin
                        r_req       <= '{addr: imem_addr, wdata: '0,
                                         wstrb: '0, instr: 1'b1};
                        r_mem_valid <= 1'b1;
                        r_state     <= GRANT_I;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (w_done) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_last      <= w_in_i ? INSTR : DATA;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    assign memory_valid = r_mem_valid;
    assign memory_instr = r_req.instr;
    assign memory_addr  = r_req.addr;
    assign memory_wdata = r_req.wdata;
    assign memory_wstrb = r_req.wstrb;

    // Timeout completion reports err with zeroed data; a real ready in the
    // same cycle takes precedence.
    assign imem_ready = w_in_i && w_done;
    assign imem_err   = w_in_i && w_expired && !memory_ready;
    assign imem_rdata = (w_in_i && memory_ready) ? memory_rdata : '0;

    assign dmem_ready = w_in_d && w_done;
    assign dmem_err   = w_in_d && w_expired && !memory_ready;
    assign dmem_rdata = (w_in_d && memory_ready) ? memory_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Scoreboard bench for mem_arbiter (TIMEOUT = 8, DATA_FIRST = 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    typedef struct {
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_err;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_err;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mem_arbiter #(
        .TIMEOUT    (8),
        .DATA_FIRST (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_valid   (imem_valid),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .imem_err     (imem_err),
        .dmem_valid   (dmem_valid),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_rdata   (dmem_rdata),
        .dmem_ready   (dmem_ready),
        .dmem_err     (dmem_err),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_i(input logic [31:0] a);
        exp_t e;
        e.instr = 1'b1; e.addr = a; e.wdata = '0; e.wstrb = 4'h0;
        sb.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_t e;
        e.instr = 1'b0; e.addr = a; e.wdata = wd; e.wstrb = ws;
        sb.push_back(e);
    endtask

    // Plays the memory side of one transaction: waits for the bus request,
    // checks it against the scoreboard head, stalls `lat` cycles, then either
    // completes with `rd` or lets the arbiter time out.
    task automatic bus_txn(input int lat, input logic [31:0] rd, input bit to);
        exp_t e;
        int   waited = 0;
        logic rdy_x, err_x, rdy_o;
        logic [31:0] rdata_x;
        while (!memory_valid && waited < 20) begin
            tick();
            waited++;
        end
        n_checks++;
        if (!memory_valid) begin
            $display("FAIL bus_wait: memory_valid never rose within 20 cycles");
            return;
        end else n_pass++;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL sb_empty: bus request with no expected entry");
            return;
        end
        e = sb.pop_front();
        n_checks++;
        if (memory_instr !== e.instr) $display("FAIL grant_port: memory_instr got %b want %b", memory_instr, e.instr);
        else n_pass++;
        n_checks++;
        if (memory_addr !== e.addr) $display("FAIL bus_addr: got %h want %h", memory_addr, e.addr);
        else n_pass++;
        n_checks++;
        if (memory_wstrb !== e.wstrb) $display("FAIL bus_wstrb: got %h want %h", memory_wstrb, e.wstrb);
        else n_pass++;
        if (!e.instr) begin
            n_checks++;
            if (memory_wdata !== e.wdata) $display("FAIL bus_wdata: got %h want %h", memory_wdata, e.wdata);
            else n_pass++;
        end
        for (int i = 0; i < lat; i++) begin
            memory_ready = 1'b0;
            #1;
            n_checks++;
            if (imem_ready !== 1'b0 || dmem_ready !== 1'b0)
                $display("FAIL early_ready: cycle %0d imem_ready %b dmem_ready %b want 0/0", i, imem_ready, dmem_ready);
            else n_pass++;
            tick();
        end
        memory_ready = !to;
        memory_rdata = rd;
        #1;
        rdy_x   = e.instr ? imem_ready : dmem_ready;
        err_x   = e.instr ? imem_err   : dmem_err;
        rdata_x = e.instr ? imem_rdata : dmem_rdata;
        rdy_o   = e.instr ? dmem_ready : imem_ready;
        n_checks++;
        if (rdy_x !== 1'b1) $display("FAIL port_ready: got %b want 1 (instr=%b)", rdy_x, e.instr);
        else n_pass++;
        n_checks++;
        if (err_x !== to) $display("FAIL port_err: got %b want %b", err_x, to);
        else n_pass++;
        n_checks++;
        if (rdata_x !== (to ? 32'h0 : rd)) $display("FAIL port_rdata: got %h want %h", rdata_x, to ? 32'h0 : rd);
        else n_pass++;
        n_checks++;
        if (rdy_o !== 1'b0) $display("FAIL other_ready: got %b want 0", rdy_o);
        else n_pass++;
        if (e.instr) imem_valid = 1'b0;
        else dmem_valid = 1'b0;
        tick();
        memory_ready = 1'b0;
        #1;
        n_checks++;
        if (memory_valid !== 1'b0 || imem_ready !== 1'b0 || dmem_ready !== 1'b0 || imem_err !== 1'b0 || dmem_err !== 1'b0)
            $display("FAIL post_done: valid %b iready %b dready %b ierr %b derr %b want all 0",
                     memory_valid, imem_ready, dmem_ready, imem_err, dmem_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_valid = 1'b0; imem_addr = '0;
        dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        memory_rdata = '0; memory_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++;
        if ({memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb} !== '0)
            $display("FAIL reset_bus: valid %b instr %b addr %h wdata %h wstrb %h want all 0",
                     memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb);
        else n_pass++;
        n_checks++;
        if ({imem_ready, imem_err, dmem_ready, dmem_err} !== 4'b0)
            $display("FAIL reset_ready: got %b want 0000", {imem_ready, imem_err, dmem_ready, dmem_err});
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        imem_valid = 1'b1;
        imem_addr  = 32'h100;
        #1;
        n_checks++;
        if (memory_valid !== 1'b0) $display("FAIL fetch_n: memory_valid got %b want 0", memory_valid);
        else n_pass++;
        push_i(32'h100);
        tick();
        n_checks++;
        if (memory_valid !== 1'b1) $display("FAIL fetch_latency: memory_valid got %b want 1", memory_valid);
        else n_pass++;
        bus_txn(3, 32'hDEADBEEF, 1'b0);
    endtask

    task automatic test_back_to_back();
        dmem_valid = 1'b1; dmem_addr = 32'h200; dmem_wdata = 32'h12345678; dmem_wstrb = 4'hF;
        imem_valid = 1'b1; imem_addr = 32'h104;
        push_d(32'h200, 32'h12345678, 4'hF);
        push_i(32'h104);
        tick();
        bus_txn(1, 32'hA5A5_0001, 1'b0);
        tick();
        n_checks++;
        if (memory_valid !== 1'b1) $display("FAIL reissue_m2: memory_valid got %b want 1", memory_valid);
        else n_pass++;
        bus_txn(0, 32'h0BAD_F00D, 1'b0);
    endtask

    task automatic test_round_robin();
        logic [31:0] ia = 32'h1000;
        logic [31:0] da = 32'h2000;
        bit          served_i;
        imem_valid = 1'b1; imem_addr = ia;
        dmem_valid = 1'b1; dmem_addr = da; dmem_wdata = 32'hC0DE_0000; dmem_wstrb = 4'h3;
        push_d(da, 32'hC0DE_0000, 4'h3);
        push_i(ia);
        tick();
        for (int k = 0; k < 6; k++) begin
            served_i = (k % 2) == 1;
            bus_txn(k % 3, 32'h5000_0000 + k, 1'b0);
            if (k < 4) begin
                if (served_i) begin
                    ia = ia + 4; imem_addr = ia; imem_valid = 1'b1;
                    push_i(ia);
                end else begin
                    da = da + 8; dmem_addr = da; dmem_wdata = 32'hC0DE_0000 + k;
                    dmem_wstrb = 4'h1 << (k % 4); dmem_valid = 1'b1;
                    push_d(da, 32'hC0DE_0000 + k, 4'h1 << (k % 4));
                end
            end
        end
    endtask

    task automatic test_timeout();
        dmem_valid = 1'b1; dmem_addr = 32'h300; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        push_d(32'h300, 32'h0, 4'h0);
        tick();
        bus_txn(7, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_reset_mid();
        imem_valid = 1'b1; imem_addr = 32'h400;
        tick();
        n_checks++;
        if (memory_valid !== 1'b1) $display("FAIL mid_grant: memory_valid got %b want 1", memory_valid);
        else n_pass++;
        tick();
        rst = 1'b1;
        imem_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (memory_valid !== 1'b0) $display("FAIL mid_reset_valid: memory_valid got %b want 0", memory_valid);
        else n_pass++;
        tick();
        memory_ready = 1'b1; memory_rdata = 32'h7777_7777;
        #1;
        n_checks++;
        if (imem_ready !== 1'b0 || dmem_ready !== 1'b0 || imem_err !== 1'b0)
            $display("FAIL mid_late_ready: iready %b dready %b ierr %b want 0", imem_ready, dmem_ready, imem_err);
        else n_pass++;
        n_checks++;
        if (imem_rdata !== 32'h0) $display("FAIL mid_rdata: got %h want 0", imem_rdata);
        else n_pass++;
        tick();
        memory_ready = 1'b0;
        #1;
        n_checks++;
        if (memory_valid !== 1'b0) $display("FAIL mid_idle: memory_valid got %b want 0", memory_valid);
        else n_pass++;
    endtask

    task automatic test_spurious_ready();
        for (int i = 0; i < 3; i++) begin
            memory_ready = 1'b1; memory_rdata = 32'h1234_0000 + i;
            #1;
            n_checks++;
            if ({imem_ready, imem_err, dmem_ready, dmem_err} !== 4'b0 || imem_rdata !== '0 || dmem_rdata !== '0)
                $display("FAIL spurious: ready/err %b irdata %h drdata %h want 0",
                         {imem_ready, imem_err, dmem_ready, dmem_err}, imem_rdata, dmem_rdata);
            else n_pass++;
            tick();
        end
        memory_ready = 1'b0;
        #1;
        n_checks++;
        if (memory_valid !== 1'b0) $display("FAIL spurious_valid: memory_valid got %b want 0", memory_valid);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        tick();
        test_single_fetch();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_spurious_ready();
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d entries want 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single cpu memory bus between two requesters: an instruction-fetch port (imem) and a load/store port (dmem).
- Sits between a split-port cpu core and the memory model or controller.
- Grants one transaction at a time and registers the winning request onto the memory bus.
- Returns ready and rdata only to the granted port; times out transactions that never see memory_ready.

Parameters:
- TIMEOUT, 1024, cycles memory_valid may stay high without memory_ready before the arbiter aborts; 0 disables the timeout.
- DATA_FIRST, 1, tie-break when both ports request in IDLE with no history (right after reset): 1 = dmem wins, 0 = imem wins.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imem_valid  in  1  fetch request; held high until imem_ready
- imem_addr  in  32  fetch address
- imem_rdata  out  32  fetch data; valid while imem_ready
- imem_ready  out  1  one-cycle completion pulse
- imem_err  out  1  one-cycle pulse with imem_ready when the fetch timed out
- dmem_valid  in  1  load/store request; held high until dmem_ready
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte strobes; 0 = load
- dmem_rdata  out  32  load data; valid while dmem_ready
- dmem_ready  out  1  one-cycle completion pulse
- dmem_err  out  1  one-cycle pulse with dmem_ready when the access timed out
- memory_valid  out  1  bus request
- memory_instr  out  1  1 = transaction belongs to imem
- memory_addr  out  32  bus address
- memory_wdata  out  32  bus store data
- memory_wstrb  out  4  bus strobes; forced to 0 for imem
- memory_rdata  in  32  bus read data
- memory_ready  in  1  bus completion pulse

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, last_grant = none, timeout counter = 0.
  - memory_valid, memory_instr, memory_addr, memory_wdata and memory_wstrb all 0.
  - All ready and err outputs 0.
  - rst mid-transaction abandons it. No ready is ever returned for it, and a memory_ready arriving after reset is ignored.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE, arbitration:
  - Only imem_valid -> GRANT_I; only dmem_valid -> GRANT_D.
  - Both valid -> the port not served last (round robin). If last_grant = none, use DATA_FIRST.
  - On the grant edge, latch addr/wdata/wstrb (wstrb = 0 for imem) and set memory_instr.
  - memory_valid goes high on the same edge, so it is visible the cycle after the request is seen. Minimum latency: request sampled at cycle N, memory_valid high in N+1.
- GRANT_x:
  - Bus outputs hold their latched values; requester inputs are not re-sampled.
  - memory_ready high in cycle M: x_ready = 1 and x_rdata = memory_rdata combinationally in cycle M, other port's ready = 0.
  - Edge ending M: memory_valid <= 0, state <= IDLE, last_grant <= x.
  - Earliest next memory_valid is cycle M+2.
- Non-granted port:
  - Ready is 0 and rdata is 0 whenever that port's ready is low.
  - Its request is queued implicitly by its held valid.
- Timeout (TIMEOUT > 0):
  - Counter clears on each grant and increments each cycle in GRANT_x while memory_ready = 0.
  - Counter reaching TIMEOUT-1 without ready: that cycle x_ready = 1, x_err = 1, x_rdata = 0; then -> IDLE with memory_valid dropped.
  - If memory_ready arrives in that same cycle, normal completion wins and err = 0.
- memory_ready while in IDLE: ignored, produces no ready pulse.
- Requester dropping valid before its ready is a protocol violation. The arbiter completes the latched transaction and pulses ready anyway.
- No combinational path from imem_valid or dmem_valid to any memory_* output.

Decomposition:
- Shared package mem_pkg holds:
  - enum arb_state_t {IDLE, GRANT_I, GRANT_D} and enum grant_t {NONE, INSTR, DATA}.
  - Struct mem_req_t {addr, wdata, wstrb, instr} used for the latched request.
  - Localparams for the bus widths.
- One natural sub-module: arb_timeout_counter (clear / enable / expired; width $clog2(TIMEOUT+1)).

Test Plan:
- Single fetch: imem_valid, addr 0x100; memory returns ready 3 cycles later with rdata 0xDEADBEEF -> memory_valid from N+1, memory_instr = 1, wstrb = 0; imem_ready with rdata 0xDEADBEEF in the ready cycle; dmem_ready stays 0.
- Simultaneous after reset, DATA_FIRST = 1, both held: dmem store 0x200 / wdata 0x12345678 / wstrb 0xF and imem fetch 0x104 -> dmem served first. Then imem, with memory_valid re-asserted 2 cycles after the first ready.
- Round robin: both ports continuously valid for 6 transactions -> grant order D, I, D, I, D, I.
- Timeout, TIMEOUT = 8: dmem load to 0x300, memory never ready -> dmem_ready = dmem_err = 1 and rdata = 0 in the 8th grant cycle; memory_valid low the next cycle.
- Reset mid-transaction: rst in 2nd GRANT_I cycle, memory_ready arrives 1 cycle after reset releases -> no imem_ready, memory_valid 0, state IDLE.
- Spurious memory_ready in IDLE -> no ready or err pulse on either port.
